// File: rtl/std_dffber_wrseq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : std_dffber_wrseq                                           |
// | Description : Read-modify-write sequencer for a bit-enable DFF bank.     |
// |               Queues WRITE/SET/CLEAR requests, converts the head entry   |
// |               into a one-cycle per-bit enable/data pulse for the bank,   |
// |               and returns the pre-write bank value on a response channel.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   WIDTH         register width (must match the downstream bank)          |
// |   WRITABLE_MASK per-bit write permission; 0 bits never get wr_en         |
// |   FIFO_DEPTH    request queue depth, 1 or 2                              |
// | Optional feature macro                                                   |
// |   STD_DFFBER_WRSEQ_ERRCHK_EN  enables request checking and rsp_err;      |
// |   when undefined rsp_err is tied to 0 and writes are masked only.        |
// | Ports                                                                    |
// |   clk, resetn           clock, async active-low reset                    |
// |   req_valid/req_ready   request handshake                                |
// |   req_op[1:0]           00 WRITE, 01 SET, 10 CLEAR, 11 reserved          |
// |   req_src[WIDTH]        write data (WRITE) or bit mask (SET/CLEAR)       |
// |   q_in[WIDTH]           bank q read-back                                 |
// |   wr_en/wr_d[WIDTH]     registered per-bit enable and data to the bank   |
// |   rsp_valid/rsp_ready   response handshake                               |
// |   rsp_old[WIDTH]        q_in sampled when the request was issued         |
// |   rsp_err               request error flag                               |
// +--------------------------------------------------------------------------+

module std_dffber_wrseq #(
  parameter int                 WIDTH         = 1,
  parameter logic [WIDTH-1:0]   WRITABLE_MASK = {WIDTH{1'b1}},
  parameter int                 FIFO_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_src,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] wr_en,
  output logic [WIDTH-1:0] wr_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_old,
  output logic             rsp_err
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic       PTR_LAST = 1'(FIFO_DEPTH - 1);
  localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Request queue: entries are {op, src}
  // ---------------------------------------------------------------------
  logic [WIDTH+1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state_q;
  state_t           state_d;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == 2'd0);

  // Ready is masked by reset so the channel looks closed while held in reset.
  assign req_ready = resetn & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == IDLE) & ~empty;

  // Storage needs no reset: the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_op, req_src};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? 1'b0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? 1'b0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  logic [WIDTH+1:0] head;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_src;

  assign head     = mem_q[rd_ptr_q];
  assign head_op  = head[WIDTH+1:WIDTH];
  assign head_src = head[WIDTH-1:0];

  // ---------------------------------------------------------------------
  // Enable / data generation from the head entry
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] gen_en;
  logic [WIDTH-1:0] gen_d;
  logic [WIDTH-1:0] gen_en_final;

  always_comb begin
    gen_en = '0;
    gen_d  = '0;
    case (head_op)
      OP_WRITE: begin
        gen_en = WRITABLE_MASK;
        gen_d  = head_src;
      end
      OP_SET: begin
        gen_en = head_src & WRITABLE_MASK;
        gen_d  = '1;
      end
      OP_CLEAR: begin
        gen_en = head_src & WRITABLE_MASK;
        gen_d  = '0;
      end
      default: begin
        gen_en = '0;
        gen_d  = '0;
      end
    endcase
  end

`ifdef STD_DFFBER_WRSEQ_ERRCHK_EN
  logic gen_err;
  logic err_q;

  // A WRITE may only change writable bits; SET/CLEAR may only target them.
  always_comb begin
    gen_err = 1'b0;
    case (head_op)
      OP_WRITE: gen_err = |((head_src ^ q_in) & ~WRITABLE_MASK);
      OP_SET,
      OP_CLEAR: gen_err = |(head_src & ~WRITABLE_MASK);
      default:  gen_err = 1'b1;
    endcase
  end

  assign gen_en_final = gen_err ? '0 : gen_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (pop) begin
      err_q <= gen_err;
    end
  end

  assign rsp_err = err_q;
`else
  assign gen_en_final = gen_en;
  assign rsp_err      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] wr_en_q;
  logic [WIDTH-1:0] wr_en_d;
  logic [WIDTH-1:0] wr_d_q;
  logic [WIDTH-1:0] wr_d_d;
  logic [WIDTH-1:0] rsp_old_q;
  logic [WIDTH-1:0] rsp_old_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wr_en_q   <= '0;
      wr_d_q    <= '0;
      rsp_old_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_d_q    <= wr_d_d;
      rsp_old_q <= rsp_old_d;
    end
  end

  // wr_en defaults to 0 so the enable is a single-cycle pulse out of IDLE.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = '0;
    wr_d_d    = wr_d_q;
    rsp_old_d = rsp_old_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          wr_en_d   = gen_en_final;
          wr_d_d    = gen_d;
          rsp_old_d = q_in;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_d      = wr_d_q;
  assign rsp_old   = rsp_old_q;
  assign rsp_valid = (state_q == RESP);

endmodule

`default_nettype wire

// File: tb/tb_std_dffber_wrseq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_std_dffber_wrseq                                        |
// | Description : Directed self-checking bench for std_dffber_wrseq with     |
// |               WIDTH=8, WRITABLE_MASK=8'hF0, FIFO_DEPTH=2 and a simple    |
// |               bit-enable bank model feeding q_in.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_std_dffber_wrseq;

`ifdef STD_DFFBER_WRSEQ_ERRCHK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_src;
  logic [7:0] q_in;
  logic [7:0] wr_en;
  logic [7:0] wr_d;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_old;
  logic       rsp_err;

  logic       bank_load;
  logic [7:0] bank_val;
  logic [7:0] bank_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  std_dffber_wrseq #(
    .WIDTH         (8),
    .WRITABLE_MASK (8'hF0),
    .FIFO_DEPTH    (2)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src   (req_src),
    .q_in      (q_in),
    .wr_en     (wr_en),
    .wr_d      (wr_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_old   (rsp_old),
    .rsp_err   (rsp_err)
  );

  // Downstream bit-enable bank; bank_load presets it between scenarios.
  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else           bank_q <= (bank_q & ~wr_en) | (wr_d & wr_en);
  end
  assign q_in = bank_q;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [7:0] v);
    bank_val  = v;
    bank_load = 1'b1;
    tick();
    bank_load = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src   = 8'h00;
    rsp_ready = 1'b0;
    bank_load = 1'b1;
    bank_val  = 8'h00;

    // ---------------- reset then idle ----------------
    repeat (3) tick();
    chk("rst_wr_en",     wr_en,             8'h00);
    chk("rst_wr_d",      wr_d,              8'h00);
    chk("rst_rsp_valid", 8'(rsp_valid),     8'h00);
    chk("rst_rsp_old",   rsp_old,           8'h00);
    chk("rst_rsp_err",   8'(rsp_err),       8'h00);
    chk("rst_req_ready", 8'(req_ready),     8'h00);
    bank_load = 1'b0;
    resetn    = 1'b1;
    #1;
    chk("rel_req_ready", 8'(req_ready),     8'h01);
    tick();
    tick();
    chk("idle_wr_en",    wr_en,             8'h00);

    // ---------------- single WRITE ----------------
    load_bank(8'h0F);
    req_valid = 1'b1; req_op = 2'b00; req_src = 8'hA5;
    tick();                                   // accepted
    req_valid = 1'b0;
    chk("wr_pre_en",     wr_en,             8'h00);
    tick();                                   // ISSUE
    chk("wr_en",         wr_en,             ERR ? 8'h00 : 8'hF0);
    chk("wr_d",          wr_d,              8'hA5);
    chk("wr_rsp_early",  8'(rsp_valid),     8'h00);
    tick();                                   // RESP
    chk("wr_en_pulse",   wr_en,             8'h00);
    chk("wr_rsp_valid",  8'(rsp_valid),     8'h01);
    chk("wr_rsp_old",    rsp_old,           8'h0F);
    chk("wr_rsp_err",    8'(rsp_err),       8'(ERR));
    rsp_ready = 1'b1;
    tick();
    chk("wr_rsp_done",   8'(rsp_valid),     8'h00);

    // ------- SET, CLEAR, reserved, WRITE back-to-back; queue fills -------
    load_bank(8'h00);
    req_valid = 1'b1; req_op = 2'b01; req_src = 8'h3C;   // A: SET
    chk("b2b_ready0",    8'(req_ready),     8'h01);
    tick();
    req_op = 2'b10; req_src = 8'h90;                     // B: CLEAR
    tick();
    chk("set_en",        wr_en,             ERR ? 8'h00 : 8'h30);
    chk("set_d",         wr_d,              8'hFF);
    req_op = 2'b11; req_src = 8'hFF;                     // C: reserved
    tick();
    chk("set_rsp_valid", 8'(rsp_valid),     8'h01);
    chk("set_rsp_old",   rsp_old,           8'h00);
    chk("set_rsp_err",   8'(rsp_err),       8'(ERR));
    chk("full_ready",    8'(req_ready),     8'h00);
    req_op = 2'b00; req_src = 8'h50;                     // D: WRITE, stalls
    tick();
    chk("set_rsp_done",  8'(rsp_valid),     8'h00);
    chk("stall_ready",   8'(req_ready),     8'h00);
    tick();
    chk("clr_en",        wr_en,             8'h90);
    chk("clr_d",         wr_d,              8'h00);
    chk("pop_ready",     8'(req_ready),     8'h01);
    tick();                                              // D accepted
    req_valid = 1'b0;
    chk("clr_rsp_valid", 8'(rsp_valid),     8'h01);
    chk("clr_rsp_old",   rsp_old,           ERR ? 8'h00 : 8'h30);
    chk("clr_rsp_err",   8'(rsp_err),       8'h00);
    tick();
    tick();
    chk("rsv_en",        wr_en,             8'h00);
    chk("rsv_d",         wr_d,              8'h00);
    tick();
    chk("rsv_rsp_valid", 8'(rsp_valid),     8'h01);
    chk("rsv_rsp_old",   rsp_old,           ERR ? 8'h00 : 8'h20);
    chk("rsv_rsp_err",   8'(rsp_err),       8'(ERR));
    tick();
    tick();
    chk("d_en",          wr_en,             8'hF0);
    chk("d_d",           wr_d,              8'h50);
    tick();
    chk("d_rsp_valid",   8'(rsp_valid),     8'h01);
    chk("d_rsp_old",     rsp_old,           ERR ? 8'h00 : 8'h20);
    chk("d_rsp_err",     8'(rsp_err),       8'h00);
    tick();
    chk("d_rsp_done",    8'(rsp_valid),     8'h00);

    // ---------------- response backpressure ----------------
    load_bank(8'h40);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_src = 8'hB0;
    tick();
    req_op = 2'b01; req_src = 8'h10;
    tick();
    req_valid = 1'b0;
    chk("bp_en",         wr_en,             8'hF0);
    chk("bp_d",          wr_d,              8'hB0);
    tick();
    chk("bp_rsp_valid",  8'(rsp_valid),     8'h01);
    chk("bp_rsp_old",    rsp_old,           8'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 8'(rsp_valid),   8'h01);
      chk("bp_hold_old",   rsp_old,         8'h40);
      chk("bp_hold_en",    wr_en,           8'h00);
      chk("bp_hold_ready", 8'(req_ready),   8'h01);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_done",   8'(rsp_valid),     8'h00);
    tick();
    chk("bp2_en",        wr_en,             8'h10);
    chk("bp2_d",         wr_d,              8'hFF);
    tick();
    chk("bp2_rsp_valid", 8'(rsp_valid),     8'h01);
    chk("bp2_rsp_old",   rsp_old,           8'hB0);
    chk("bp2_rsp_err",   8'(rsp_err),       8'h00);
    tick();

    // ---------------- reset during ISSUE ----------------
    load_bank(8'h00);
    req_valid = 1'b1; req_op = 2'b00; req_src = 8'h70;
    tick();
    req_op = 2'b01; req_src = 8'h20;
    tick();
    req_valid = 1'b0;
    chk("mr_en",         wr_en,             8'hF0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_en_clr",     wr_en,             8'h00);
    chk("mr_rsp_valid",  8'(rsp_valid),     8'h00);
    chk("mr_ready",      8'(req_ready),     8'h00);
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mr_post_en",    wr_en,           8'h00);
      chk("mr_post_rsp",   8'(rsp_valid),   8'h00);
      chk("mr_post_ready", 8'(req_ready),   8'h01);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
